uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter: the next generation of the fixed 8-bit single-word transmitter. It accepts words into an internal FIFO, frames each as start/data/optional parity/stop bits at a selectable baud rate using 16x oversampling, and shifts them out on TxD back-to-back. It sits between the host write interface and the serial line, in place of the single-word transmitter.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter:
// baud divisor table, parity mode and transmitter FSM state encodings.
package uart_pkg;

    localparam int DIV_W = 14;

    // Clocks per 16x oversampling tick at 50 MHz, indexed by baud_select.
    localparam logic [DIV_W-1:0] BAUD_DIV [8] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326,
        14'd163,   14'd81,   14'd54,  14'd27
    };

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // odd_ones is the XOR reduction of the data word.
    function automatic logic parity_bit(parity_mode_t mode, logic odd_ones);
        case (mode)
            PAR_EVEN: return odd_ones;
            PAR_ODD:  return !odd_ones;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port of the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Tx_WR is a level valid and !Tx_FULL is ready: one word transfers on every
    // edge with Tx_WR=1 and Tx_FULL=0; Tx_WR=1 with Tx_FULL=1 drops the word
    // and pulses Tx_OVERRUN for one cycle.
    logic              Tx_WR;
    logic [DATA_W-1:0] Tx_DATA;
    logic              Tx_FULL;
    logic              Tx_EMPTY;
    logic [LVL_W-1:0]  Tx_LEVEL;
    logic              Tx_OVERRUN;

    modport master (
        output Tx_WR, Tx_DATA,
        input  Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVERRUN
    );

    modport slave (
        input  Tx_WR, Tx_DATA,
        output Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVERRUN
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest word.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before any same-cycle pop, so a write to a full FIFO
    // is always rejected.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(do_push) - CW'(do_pop);
            overrun <= push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed framer with 16x baud ticks, optional
// parity and 1 or 2 stop bits, sending queued words back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic [1:0]        parity_mode,
    input  logic              Tx_EN,
    uart_tx_fifo_if.slave     host,
    output logic              TxD,
    output logic              Tx_BUSY,
    output tx_state_t         tx_state
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t          state, state_d;
    logic [DATA_W-1:0]  fifo_rdata;
    logic               fifo_empty, fifo_full, load;
    logic [DIV_W-1:0]   div_q, tick_cnt;
    logic [3:0]         os_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic               stop_cnt, par_bit, bit_done, txd_d;
    parity_mode_t       par_q;
    logic [DATA_W-1:0]  shreg, shreg_d;

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (host.Tx_WR),
        .pop     (load),
        .wdata   (host.Tx_DATA),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (host.Tx_LEVEL),
        .overrun (host.Tx_OVERRUN)
    );

    assign host.Tx_FULL  = fifo_full;
    assign host.Tx_EMPTY = fifo_empty;
    assign tx_state      = state;
    assign bit_done      = (tick_cnt == div_q) && (os_cnt == 4'hF);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        shreg_d = shreg;
        txd_d   = 1'b1;
        case (state)
            IDLE: if (Tx_EN && !fifo_empty) begin
                state_d = START;
                load    = 1'b1;
            end
            START: if (bit_done) state_d = DATA;
            DATA: if (bit_done) begin
                shreg_d = shreg >> 1;
                if (bit_idx == LAST_IDX) state_d = (par_q == PAR_NONE) ? STOP : PARITY;
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: if (bit_done && stop_cnt == STOP_LAST) begin
                if (Tx_EN && !fifo_empty) begin
                    state_d = START;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // TxD is registered from the next state so each bit starts on the edge
        // that ends the previous one.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            PARITY:  txd_d = par_bit;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            shreg    <= '0;
            div_q    <= '0;
            par_q    <= PAR_NONE;
            par_bit  <= 1'b0;
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            state   <= state_d;
            TxD     <= txd_d;
            Tx_BUSY <= (state_d != IDLE);
            shreg   <= load ? fifo_rdata : shreg_d;
            if (load) begin
                div_q    <= BAUD_DIV[baud_select] - DIV_W'(1);
                par_q    <= parity_mode_t'(parity_mode);
                par_bit  <= parity_bit(parity_mode_t'(parity_mode), ^fifo_rdata);
                tick_cnt <= '0;
                os_cnt   <= '0;
                bit_idx  <= '0;
                stop_cnt <= 1'b0;
            end else if (state != IDLE) begin
                if (tick_cnt == div_q) begin
                    tick_cnt <= '0;
                    os_cnt   <= os_cnt + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + DIV_W'(1);
                end
                if (bit_done && state == DATA) bit_idx  <= bit_idx + IDX_W'(1);
                if (bit_done && state == STOP) stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: instance a is 8N1-style (STOP_BITS=1),
// instance b uses STOP_BITS=2; both share one 50 MHz clock.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, rst_b, en_a, en_b;
    logic [2:0] baud_a, baud_b;
    logic [1:0] par_a, par_b;
    logic       txd_a, txd_b, busy_a, busy_b;
    tx_state_t  st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(16)) if_a ();
    uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(16)) if_b ();

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst_a), .baud_select(baud_a), .parity_mode(par_a),
        .Tx_EN(en_a), .host(if_a), .TxD(txd_a), .Tx_BUSY(busy_a), .tx_state(st_a)
    );

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst_b), .baud_select(baud_b), .parity_mode(par_b),
        .Tx_EN(en_b), .host(if_b), .TxD(txd_b), .Tx_BUSY(busy_b), .tx_state(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input int w);
        return (w == 0) ? txd_a : txd_b;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int w, input logic [7:0] d);
        if (w == 0) begin if_a.Tx_WR = 1'b1; if_a.Tx_DATA = d; end
        else        begin if_b.Tx_WR = 1'b1; if_b.Tx_DATA = d; end
        @(negedge clk);
        if (w == 0) if_a.Tx_WR = 1'b0;
        else        if_b.Tx_WR = 1'b0;
    endtask

    // Returns on the first negedge with TxD low, i.e. just after the start edge.
    task automatic wait_start(input int w, input string tag);
        int n = 0;
        while (txd_of(w) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start seen"}, 32'(txd_of(w)), 32'd0);
    endtask

    // Samples each bit mid-period, then measures busy time from the start edge.
    task automatic check_frame(input int w, input string tag, input logic [15:0] bits,
                               input int nbits, input int blen, input int drop_at);
        int off = 0;
        for (int i = 0; i < nbits; i++) begin
            while (off < blen * i + blen / 2) begin
                @(negedge clk);
                off++;
                if (off == drop_at) begin
                    if (w == 0) en_a = 1'b0;
                    else        en_b = 1'b0;
                end
            end
            check($sformatf("%s bit%0d", tag, i), 32'(txd_of(w)), 32'(bits[i]));
        end
        while (busy_of(w) === 1'b1 && off < nbits * blen + 100) begin
            @(negedge clk);
            off++;
        end
        check({tag, " length"}, 32'(off), 32'(nbits * blen));
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        baud_a = 3'd0; baud_b = 3'd0;
        par_a = 2'd0; par_b = 2'd0;
        if_a.Tx_WR = 1'b0; if_a.Tx_DATA = '0;
        if_b.Tx_WR = 1'b0; if_b.Tx_DATA = '0;
        cycles(3);

        check("rst txd",     32'(txd_a),           32'd1);
        check("rst busy",    32'(busy_a),          32'd0);
        check("rst full",    32'(if_a.Tx_FULL),    32'd0);
        check("rst empty",   32'(if_a.Tx_EMPTY),   32'd1);
        check("rst level",   32'(if_a.Tx_LEVEL),   32'd0);
        check("rst overrun", 32'(if_a.Tx_OVERRUN), 32'd0);
        check("rst state b", 32'(st_b),            32'(IDLE));

        rst_a = 1'b1;
        rst_b = 1'b1;
        cycles(2);

        fork
            begin : thread_a
                int ovr;
                int off;
                int gaps;
                baud_a = 3'b111;
                par_a  = 2'b00;
                en_a   = 1'b1;
                push(0, 8'hDD);
                check("a wr empty", 32'(if_a.Tx_EMPTY), 32'd0);
                check("a wr level", 32'(if_a.Tx_LEVEL), 32'd1);
                check("a wr busy",  32'(busy_a),        32'd0);
                check("a wr txd",   32'(txd_a),         32'd1);
                @(negedge clk);
                check("a k1 txd",   32'(txd_a),         32'd0);
                check("a k1 busy",  32'(busy_a),        32'd1);
                check("a k1 empty", 32'(if_a.Tx_EMPTY), 32'd1);
                check_frame(0, "a 8N1", {6'b0, 1'b1, 8'hDD, 1'b0}, 10, 432, -1);

                par_a = 2'b01;
                push(0, 8'hDD);
                wait_start(0, "a even");
                par_a = 2'b10;
                check_frame(0, "a even", {5'b0, 1'b1, 1'b0, 8'hDD, 1'b0}, 11, 432, -1);

                cycles(5);
                push(0, 8'hDD);
                wait_start(0, "a odd");
                check_frame(0, "a odd", {5'b0, 1'b1, 1'b1, 8'hDD, 1'b0}, 11, 432, -1);

                en_a = 1'b0;
                par_a = 2'b00;
                ovr = 0;
                for (int i = 0; i < 17; i++) begin
                    if_a.Tx_WR = 1'b1;
                    if_a.Tx_DATA = 8'(8'h40 + i);
                    @(negedge clk);
                    if (if_a.Tx_OVERRUN) ovr++;
                    check($sformatf("a fill ovr%0d", i), 32'(if_a.Tx_OVERRUN), (i == 16) ? 32'd1 : 32'd0);
                end
                if_a.Tx_WR = 1'b0;
                check("a fill level", 32'(if_a.Tx_LEVEL), 32'd16);
                check("a fill full",  32'(if_a.Tx_FULL),  32'd1);
                check("a fill empty", 32'(if_a.Tx_EMPTY), 32'd0);
                @(negedge clk);
                check("a ovr end",    32'(if_a.Tx_OVERRUN), 32'd0);
                check("a ovr pulses", 32'(ovr),             32'd1);

                en_a = 1'b1;
                off = 0;
                gaps = 0;
                while (!(if_a.Tx_EMPTY && !busy_a) && off < 70000) begin
                    @(negedge clk);
                    off++;
                    if (!busy_a && !if_a.Tx_EMPTY) gaps++;
                end
                check("a drain length", 32'(off),           32'd69121);
                check("a drain gaps",   32'(gaps),          32'd0);
                check("a drain empty",  32'(if_a.Tx_EMPTY), 32'd1);
                check("a drain busy",   32'(busy_a),        32'd0);
                check("a drain level",  32'(if_a.Tx_LEVEL), 32'd0);
                check("a drain txd",    32'(txd_a),         32'd1);
            end
            begin : thread_b
                int hi;
                baud_b = 3'b110;
                par_b  = 2'b00;
                en_b   = 1'b1;
                push(1, 8'h25);
                wait_start(1, "b 8N2");
                check_frame(1, "b 8N2", {5'b0, 2'b11, 8'h25, 1'b0}, 11, 864, -1);

                push(1, 8'h25);
                wait_start(1, "b stop");
                cycles(9 * 864 - 1);
                check("b d7 end", 32'(txd_b), 32'd0);
                @(negedge clk);
                check("b stop begin", 32'(txd_b), 32'd1);
                hi = 0;
                while (busy_b === 1'b1 && hi < 3000) begin
                    @(negedge clk);
                    hi++;
                end
                check("b stop period", 32'(hi), 32'd1728);

                en_b = 1'b0;
                push(1, 8'h11);
                push(1, 8'h22);
                push(1, 8'h33);
                check("b queued", 32'(if_b.Tx_LEVEL), 32'd3);
                en_b = 1'b1;
                wait_start(1, "b endrop");
                check("b popped", 32'(if_b.Tx_LEVEL), 32'd2);
                check_frame(1, "b endrop", {5'b0, 2'b11, 8'h11, 1'b0}, 11, 864, 3 * 864);
                check("b endrop level", 32'(if_b.Tx_LEVEL), 32'd2);
                cycles(2000);
                check("b hold txd",   32'(txd_b),         32'd1);
                check("b hold busy",  32'(busy_b),        32'd0);
                check("b hold level", 32'(if_b.Tx_LEVEL), 32'd2);
                check("b hold state", 32'(st_b),          32'(IDLE));

                en_b = 1'b1;
                wait_start(1, "b reset");
                cycles(4 * 864 + 432);
                check("b pre-reset txd", 32'(txd_b), 32'd0);
                #3;
                rst_b = 1'b0;
                #1;
                check("b async txd",     32'(txd_b),           32'd1);
                check("b async busy",    32'(busy_b),          32'd0);
                check("b async full",    32'(if_b.Tx_FULL),    32'd0);
                check("b async empty",   32'(if_b.Tx_EMPTY),   32'd1);
                check("b async level",   32'(if_b.Tx_LEVEL),   32'd0);
                check("b async overrun", 32'(if_b.Tx_OVERRUN), 32'd0);
                check("b async state",   32'(st_b),            32'(IDLE));
                @(negedge clk);
                rst_b = 1'b1;
                cycles(2000);
                check("b post busy",  32'(busy_b),        32'd0);
                check("b post txd",   32'(txd_b),         32'd1);
                check("b post level", 32'(if_b.Tx_LEVEL), 32'd0);
                check("b post empty", 32'(if_b.Tx_EMPTY), 32'd1);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
